// File: rtl/display_share_arbiter.sv
// Round-robin owner selection for the shared 8-digit hex display.
// An owner keeps the display for a minimum dwell before it rotates to the next requester.
module display_share_arbiter #(
  parameter int          HOLD_CYCLES = 25_000_000,
  parameter int          HOLD_W      = 25,
  parameter logic [31:0] BLANK_WORD  = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        active,
  output logic        switch_p,
  output logic [31:0] disp_data
);

  localparam logic [HOLD_W-1:0] DWELL_MAX = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] dwell_q, dwell_d;
  logic [3:0]        grant_d;
  logic [1:0]        owner_d;
  logic              switch_d;
  logic [31:0]       disp_d;
  logic [31:0]       owner_data;
  logic [2:0]        pick_all, pick_oth;

  // Returns {found, index}; scans last+1, last+2, ... wrapping through all four slots.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [HOLD_W-1:0] dwell_sat_inc(input logic [HOLD_W-1:0] d);
    return (d == DWELL_MAX) ? d : d + HOLD_W'(1);
  endfunction

  always_comb begin
    case (owner)
      2'd0:    owner_data = data0;
      2'd1:    owner_data = data1;
      2'd2:    owner_data = data2;
      default: owner_data = data3;
    endcase
  end

  // The current owner is masked out so release and rotation both move to someone else.
  assign pick_all = rr_pick(req, owner);
  assign pick_oth = rr_pick(req & ~(4'b0001 << owner), owner);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    owner_d  = owner;
    dwell_d  = dwell_q;
    switch_d = 1'b0;
    disp_d   = BLANK_WORD;
    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d  = OWN;
          grant_d  = 4'b0001 << pick_all[1:0];
          owner_d  = pick_all[1:0];
          dwell_d  = '0;
          switch_d = 1'b1;
        end
      end
      default: begin
        disp_d  = owner_data;
        dwell_d = dwell_sat_inc(dwell_q);
        if (!req[owner]) begin
          switch_d = 1'b1;
          dwell_d  = '0;
          if (pick_oth[2]) begin
            grant_d = 4'b0001 << pick_oth[1:0];
            owner_d = pick_oth[1:0];
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            disp_d  = BLANK_WORD;
          end
        end else if (dwell_q == DWELL_MAX && pick_oth[2]) begin
          switch_d = 1'b1;
          dwell_d  = '0;
          grant_d  = 4'b0001 << pick_oth[1:0];
          owner_d  = pick_oth[1:0];
        end
      end
    endcase
  end

  // Registered output stage; owner resets to 3 so the first search starts at requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dwell_q   <= '0;
      grant     <= 4'b0000;
      owner     <= 2'd3;
      active    <= 1'b0;
      switch_p  <= 1'b0;
      disp_data <= BLANK_WORD;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      grant     <= grant_d;
      owner     <= owner_d;
      active    <= (state_d == OWN);
      switch_p  <= switch_d;
      disp_data <= disp_d;
    end
  end

endmodule
